// File: rtl/handshake_fifo_buffer.sv
// Elastic valid/ready FIFO. Output valid and input ready are decoded from registered
// occupancy only, so outs_ready has no combinational path to ins_ready.
module handshake_fifo_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ins,
   input  logic                  ins_valid,
   output logic                  ins_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] storage [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic                  push;
   logic                  pop;

   assign outs_valid = (count != '0);
   assign ins_ready  = (count != FULL_COUNT);
   assign outs       = storage[rd_ptr];

   assign push = ins_valid & ins_ready;
   assign pop  = outs_valid & outs_ready;

   // NOTE: storage is reset because outs must read 0 after reset; a plain RAM could not do this.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            storage[i] <= '0;
         end
      end else if (push) begin
         storage[wr_ptr] <= ins;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Directed bench for handshake_fifo_buffer: a DEPTH=2 instance for the directed
// scenarios and a DEPTH=4 instance for randomised backpressure against a queue model.
module tb_handshake_fifo_buffer;

   localparam int DW = 37;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] ins, outs, ins4, outs4;
   logic          ins_valid, ins_ready, outs_valid, outs_ready;
   logic          ins_valid4, ins_ready4, outs_valid4, outs_ready4;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   handshake_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
      .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready)
   );

   handshake_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(4)) dut4 (
      .clk(clk), .rst(rst), .ins(ins4), .ins_valid(ins_valid4), .ins_ready(ins_ready4),
      .outs(outs4), .outs_valid(outs_valid4), .outs_ready(outs_ready4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ins = 37'h1F_FFFF_FFFF;
      ins_valid = 1'b1;
      outs_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (outs_valid !== 1'b0 || ins_ready !== 1'b1 || outs !== '0)
            $display("FAIL reset_hold cyc%0d: valid=%b ready=%b outs=%h, want valid=0 ready=1 outs=0",
                     i, outs_valid, ins_ready, outs);
         else n_pass++;
      end
      rst = 1'b1;
      ins_valid = 1'b0;
      outs_ready = 1'b0;
      step();
      ins = 37'h00_0000_00AA; ins_valid = 1'b1; step();
      ins = 37'h00_0000_00BB; step();
      ins_valid = 1'b0;
      n_checks++;
      if (ins_ready !== 1'b0 || outs_valid !== 1'b1 || outs !== 37'h00_0000_00AA)
         $display("FAIL reset_pre_full: ready=%b valid=%b outs=%h, want ready=0 valid=1 outs=aa",
                  ins_ready, outs_valid, outs);
      else n_pass++;
      #3 rst = 1'b0;
      #1;
      n_checks++;
      if (outs_valid !== 1'b0 || ins_ready !== 1'b1 || outs !== '0)
         $display("FAIL reset_async: valid=%b ready=%b outs=%h, want valid=0 ready=1 outs=0",
                  outs_valid, ins_ready, outs);
      else n_pass++;
      step();
      rst = 1'b1;
      step();
      n_checks++;
      if (outs_valid !== 1'b0 || ins_ready !== 1'b1)
         $display("FAIL reset_release: valid=%b ready=%b, want valid=0 ready=1", outs_valid, ins_ready);
      else n_pass++;
   endtask

   task automatic test_single();
      ins = 37'h0E_186A_BA8A;
      ins_valid = 1'b1;
      outs_ready = 1'b1;
      n_checks++;
      if (outs_valid !== 1'b0)
         $display("FAIL single_no_bypass: valid=%b want 0", outs_valid);
      else n_pass++;
      step();
      ins_valid = 1'b0;
      ins = '0;
      n_checks++;
      if (outs_valid !== 1'b1 || outs !== 37'h0E_186A_BA8A)
         $display("FAIL single_out: valid=%b outs=%h, want valid=1 outs=0e186aba8a", outs_valid, outs);
      else n_pass++;
      step();
      n_checks++;
      if (outs_valid !== 1'b0)
         $display("FAIL single_after: valid=%b want 0", outs_valid);
      else n_pass++;
   endtask

   task automatic test_fill_stall();
      outs_ready = 1'b0;
      ins_valid = 1'b1;
      ins = 37'h1;
      step();
      n_checks++;
      if (ins_ready !== 1'b1 || outs_valid !== 1'b1 || outs !== 37'h1)
         $display("FAIL fill_first: ready=%b valid=%b outs=%h, want 1 1 1", ins_ready, outs_valid, outs);
      else n_pass++;
      ins = 37'h2;
      step();
      n_checks++;
      if (ins_ready !== 1'b0)
         $display("FAIL fill_full_ready: ready=%b want 0", ins_ready);
      else n_pass++;
      ins = 37'h3;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if (ins_ready !== 1'b0 || outs_valid !== 1'b1 || outs !== 37'h1)
            $display("FAIL stall_hold cyc%0d: ready=%b valid=%b outs=%h, want 0 1 1",
                     i, ins_ready, outs_valid, outs);
         else n_pass++;
      end
   endtask

   task automatic test_drain();
      outs_ready = 1'b1;
      step();
      n_checks++;
      if (ins_ready !== 1'b1 || outs_valid !== 1'b1 || outs !== 37'h2)
         $display("FAIL drain_second: ready=%b valid=%b outs=%h, want 1 1 2", ins_ready, outs_valid, outs);
      else n_pass++;
      step();
      ins_valid = 1'b0;
      n_checks++;
      if (outs_valid !== 1'b1 || outs !== 37'h3)
         $display("FAIL drain_third: valid=%b outs=%h, want 1 3", outs_valid, outs);
      else n_pass++;
      step();
      n_checks++;
      if (outs_valid !== 1'b0 || ins_ready !== 1'b1)
         $display("FAIL drain_empty: valid=%b ready=%b, want 0 1", outs_valid, ins_ready);
      else n_pass++;
   endtask

   task automatic test_streaming();
      ins_valid = 1'b1;
      outs_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         ins = DW'(i);
         step();
         n_checks++;
         if (outs_valid !== 1'b1 || outs !== DW'(i))
            $display("FAIL stream_data[%0d]: valid=%b outs=%0d, want valid=1 outs=%0d", i, outs_valid, outs, i);
         else n_pass++;
         n_checks++;
         if (ins_ready !== 1'b1 || dut.count > 2'd1)
            $display("FAIL stream_occupancy[%0d]: ready=%b count=%0d, want ready=1 count<=1",
                     i, ins_ready, dut.count);
         else n_pass++;
      end
      ins_valid = 1'b0;
      step();
      n_checks++;
      if (outs_valid !== 1'b0)
         $display("FAIL stream_end: valid=%b want 0", outs_valid);
      else n_pass++;
   endtask

   task automatic test_random_backpressure();
      logic [DW-1:0] model[$];
      logic [63:0]   r;
      logic          prev_stall = 1'b0;
      logic [DW-1:0] prev_outs = '0;
      logic          do_push, do_pop;
      int            pops = 0;
      int            errs = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         r = {$urandom(), $urandom()};
         ins4 = r[DW-1:0];
         ins_valid4 = r[40];
         outs_ready4 = r[41];
         if (prev_stall && (outs_valid4 !== 1'b1 || outs4 !== prev_outs)) begin
            errs++;
            if (errs < 10) $display("FAIL rand_stable cyc%0d: valid=%b outs=%h, want 1 %h",
                                    cyc, outs_valid4, outs4, prev_outs);
         end
         if (outs_valid4 !== (model.size() != 0) || ins_ready4 !== (model.size() != 4) ||
             dut4.count > 3'd4 || int'(dut4.count) != model.size()) begin
            errs++;
            if (errs < 10) $display("FAIL rand_flags cyc%0d: valid=%b ready=%b count=%0d, want occupancy %0d",
                                    cyc, outs_valid4, ins_ready4, dut4.count, model.size());
         end
         if (model.size() != 0 && outs4 !== model[0]) begin
            errs++;
            if (errs < 10) $display("FAIL rand_data cyc%0d: outs=%h want %h", cyc, outs4, model[0]);
         end
         do_push = ins_valid4 && (model.size() != 4);
         do_pop  = outs_ready4 && (model.size() != 0);
         prev_stall = outs_valid4 && !outs_ready4;
         prev_outs = outs4;
         step();
         if (do_pop) begin
            void'(model.pop_front());
            pops++;
         end
         if (do_push) model.push_back(ins4);
      end
      ins_valid4 = 1'b0;
      outs_ready4 = 1'b0;
      n_checks++;
      if (errs != 0) $display("FAIL rand_sequence: errors=%0d want 0", errs);
      else n_pass++;
      n_checks++;
      if (pops / 4 < 100) $display("FAIL rand_wraps: wraps=%0d want >=100", pops / 4);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b0;
      ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
      ins4 = '0; ins_valid4 = 1'b0; outs_ready4 = 1'b0;
      test_reset();
      test_single();
      test_fill_stall();
      test_drain();
      test_streaming();
      test_random_backpressure();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/handshake_fifo_buffer.md
Name: handshake_fifo_buffer

Overview:
- Elastic FIFO buffer on a valid/ready dataflow channel. Placed directly downstream of handshake constant stages.
- Decouples the constant's combinational valid/ready path (outs_valid = ctrl_valid, ctrl_ready = outs_ready) from the consumer.
- Registers both output valid and input ready, so no combinational path exists from outs_ready to ins_ready.
- Sustains one transfer per cycle.

Parameters:
- DATA_WIDTH, 32, width of the data token.
- DEPTH, 2, number of storage slots; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset asserted).
- ins  input  DATA_WIDTH  input token data.
- ins_valid  input  1  upstream token valid.
- ins_ready  output  1  buffer can accept a token.
- outs  output  DATA_WIDTH  head-of-queue token data.
- outs_valid  output  1  head token valid.
- outs_ready  input  1  downstream accepts the token.

Behaviour:
- State:
  - Storage array of DEPTH x DATA_WIDTH.
  - Write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter, log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (rst low, asynchronous, takes effect without a clock edge):
  - Pointers = 0, count = 0, storage cleared to 0.
  - Outputs: outs = 0, outs_valid = 0, ins_ready = 1.
  - Reset mid-operation discards all held tokens immediately; no partial transfer survives.
  - Release of reset is synchronous to clk.
- Outputs:
  - outs_valid = (count != 0).
  - ins_ready = (count != DEPTH).
  - Both are decoded from registered state only, with no combinational dependence on ins_valid or outs_ready.
  - outs = storage[read pointer], always driven. Value is don't-care when outs_valid = 0, except after reset (0).
- Push and pop:
  - push = ins_valid & ins_ready: write ins at the write pointer, then increment the write pointer.
  - pop = outs_valid & outs_ready: increment the read pointer.
  - Count update: push only -> +1; pop only -> -1; both or neither -> unchanged.
- Latency: a token pushed at edge N appears on outs with outs_valid = 1 after edge N. There is no same-cycle bypass.
- Empty with push and no pop: outs_valid rises next cycle. Data ordering is strictly FIFO.
- Full (count = DEPTH):
  - ins_ready = 0, so upstream holds; no write occurs even if ins_valid = 1.
  - A pop while full frees a slot, and ins_ready = 1 next cycle. A full buffer never pushes and pops in the same cycle.
- Simultaneous push and pop at 0 < count < DEPTH: both occur and count is unchanged. This gives steady-state throughput of 1 token/cycle.
- Pointer wrap-around: the pointer after DEPTH-1 is 0. No overflow or underflow is possible by construction. Assertions in the bench must confirm count never exceeds DEPTH and never goes negative.
- Channel protocol:
  - outs and outs_valid remain stable while outs_valid = 1 and outs_ready = 0.
  - The block tolerates upstream dropping ins_valid at any time.

Test Plan:
1. Reset: hold rst=0 with ins_valid=1 and clock running -> outs_valid=0, ins_ready=1, outs=0 throughout. Assert rst=0 asynchronously mid-cycle with 2 tokens held -> outs_valid falls before the next edge.
2. Single token, DATA_WIDTH=37: drive ins=0x0E186ABA8A with ins_valid=1 for one cycle and outs_ready=1 -> outs=0x0E186ABA8A and outs_valid=1 exactly one cycle later, for one cycle; then outs_valid=0.
3. Fill and stall, DEPTH=2: outs_ready=0, push 0x1 then 0x2 -> ins_ready=0 after the second push. A third ins_valid with ins=0x3 is not accepted. outs holds 0x1 stable while stalled.
4. Drain from full: from scenario 3, outs_ready=1 for 3 cycles with ins=0x3 valid -> outputs 0x1, 0x2, 0x3 in order. ins_ready=1 one cycle after the first pop.
5. Streaming: ins_valid=1 and outs_ready=1 continuously, ins = 0..99 incrementing -> 100 tokens out in order over 100 consecutive cycles after 1 cycle of latency. count never exceeds 1.
6. Random backpressure: random ins_valid and outs_ready at 50% each, 10000 cycles, DEPTH=4 -> output sequence equals input sequence. Stability assertion holds. count stays within 0..4. Pointer wrap is exercised at least 100 times.
